// File: rtl/core_pkg.sv
// Shared types for the 16-bit Harvard core: address/instruction widths,
// opcode field position and the fetch buffer entry.
package core_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic { SLOT_EMPTY, SLOT_VALID } slot_state_t;
    typedef enum logic { FS_RUN, FS_HALT }        fetch_state_t;

    function automatic logic [OPC_HI-OPC_LO:0] opcode(input logic [INSTR_W-1:0] w);
        return w[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry prefetch FIFO. Slot 0 is always the head, so the head entry is
// driven straight from a register and is never overwritten until popped.
module fetch_buffer
    import core_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slot [2];
    slot_state_t  st   [2];
    logic         do_pop, do_push;

    assign do_pop  = pop && (st[0] == SLOT_VALID);
    assign do_push = push && ((st[1] == SLOT_EMPTY) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            st[0]   <= SLOT_EMPTY;
            st[1]   <= SLOT_EMPTY;
        end else if (flush) begin
            st[0] <= SLOT_EMPTY;
            st[1] <= SLOT_EMPTY;
        end else begin
            case ({do_push, do_pop})
                2'b11: begin
                    if (st[1] == SLOT_VALID) begin
                        slot[0] <= slot[1];
                        slot[1] <= din;
                    end else begin
                        slot[0] <= din;
                    end
                end
                2'b10: begin
                    if (st[0] == SLOT_EMPTY) begin
                        slot[0] <= din;
                        st[0]   <= SLOT_VALID;
                    end else begin
                        slot[1] <= din;
                        st[1]   <= SLOT_VALID;
                    end
                end
                2'b01: begin
                    slot[0] <= slot[1];
                    st[0]   <= st[1];
                    st[1]   <= SLOT_EMPTY;
                end
                default: ;
            endcase
        end
    end

    assign head  = slot[0];
    assign count = 2'(st[0] == SLOT_VALID) + 2'(st[1] == SLOT_VALID);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, push/redirect control and prefetch buffer.
// Optional halt-on-opcode detection is enabled by FETCH_HALT_DETECT_EN.
module instruction_fetch
    import core_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = 16'd0,
    parameter logic [3:0]        HALT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  pc_address,
    input  logic [INSTR_W-1:0] instruction_in,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               fetch_valid,
    input  logic               fetch_ready,
    output logic [INSTR_W-1:0] fetch_instr,
    output logic [ADDR_W-1:0]  fetch_pc,
    output logic               halted
);

    logic [ADDR_W-1:0] pc;
    logic [1:0]        count;
    logic              pop, push;
    fetch_entry_t      head, din;

    assign fetch_valid = (count != 2'd0);
    assign pop         = fetch_valid && fetch_ready;
    assign push        = !redirect_valid && !halted && ((count < 2'd2) || pop);
    assign din         = '{pc: pc, instr: instruction_in};

    fetch_buffer u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_pc;
        else if (push)           pc <= pc + 16'd1;
    end

`ifdef FETCH_HALT_DETECT_EN
    fetch_state_t fstate;

    // The HALT word itself is still pushed; only later pushes are blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fstate <= FS_RUN;
        else if (redirect_valid)
            fstate <= FS_RUN;
        else if (push && (opcode(instruction_in) == HALT_OPCODE))
            fstate <= FS_HALT;
    end

    assign halted = (fstate == FS_HALT);
`else
    logic unused_halt_opc;
    assign unused_halt_opc = ^HALT_OPCODE;
    assign halted          = 1'b0;
`endif

    assign pc_address  = pc;
    assign fetch_instr = head.instr;
    assign fetch_pc    = head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table, directed corner sequences and
// random traffic against a queue-based reference model of the fetch rules.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc_address;
    logic [15:0] instruction_in;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        fetch_valid;
    logic        fetch_ready = 1'b0;
    logic [15:0] fetch_instr;
    logic [15:0] fetch_pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    assign instruction_in = (pc_address < 16'd256) ? mem[pc_address[7:0]]
                                                   : ((pc_address ^ 16'h0123) & 16'h7FFF);

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_address     (pc_address),
        .instruction_in (instruction_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_instr    (fetch_instr),
        .fetch_pc       (fetch_pc),
        .halted         (halted)
    );

    // Reference model: FIFO contents as a queue, plus PC and halt flag.
    typedef struct { logic [15:0] pc; logic [15:0] instr; } ent_t;
    ent_t        mq[$];
    logic [15:0] m_pc;
    bit          m_halt;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a < 16'd256) return mem[a[7:0]];
        return (a ^ 16'h0123) & 16'h7FFF;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = 16'h0000;
        m_halt = 1'b0;
    endtask

    task automatic model_edge(input bit r, input bit rv, input logic [15:0] rp);
        bit   pop, push;
        int   sz;
        ent_t e;
        if (rv) begin
            mq.delete();
            m_pc   = rp;
            m_halt = 1'b0;
        end else begin
            sz  = mq.size();
            pop = (sz > 0) && r;
            if (pop) void'(mq.pop_front());
            push = !m_halt && (sz < 2 || pop);
            if (push) begin
                e.pc    = m_pc;
                e.instr = mem_word(m_pc);
                mq.push_back(e);
`ifdef FETCH_HALT_DETECT_EN
                if (e.instr[15:12] == 4'hF) m_halt = 1'b1;
`endif
                m_pc = m_pc + 16'd1;
            end
        end
    endtask

    task automatic check_model();
        chk("valid", {15'b0, fetch_valid}, {15'b0, mq.size() != 0});
        chk("pc_address", pc_address, m_pc);
        chk("halted", {15'b0, halted}, {15'b0, m_halt});
        if (mq.size() != 0) begin
            chk("fetch_pc", fetch_pc, mq[0].pc);
            chk("fetch_instr", fetch_instr, mq[0].instr);
        end
    endtask

    task automatic step(input bit r, input bit rv, input logic [15:0] rp);
        fetch_ready    = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        @(posedge clk);
        model_edge(r, rv, rp);
        #1;
        check_model();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc_address"}, pc_address, 16'h0000);
        chk({tag, "_valid"}, {15'b0, fetch_valid}, 16'h0);
        chk({tag, "_instr"}, fetch_instr, 16'h0000);
        chk({tag, "_pc"}, fetch_pc, 16'h0000);
        chk({tag, "_halted"}, {15'b0, halted}, 16'h0);
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        fetch_ready    = 1'b0;
        redirect_valid = 1'b0;
        #3;
        chk_reset("rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          do_rst;
        bit          ready;
        bit          exp_valid;
        logic [15:0] exp_pc;
        logic [15:0] exp_instr;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = (16'(i) ^ 16'h0123) & 16'h7FFF;
        mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'h3456; mem[3] = 16'h4567;

        // streaming with ready high
        tbl[0]  = '{1, 1, 1, 16'h0000, 16'h1234, 16'h0001};
        tbl[1]  = '{0, 1, 1, 16'h0001, 16'h2345, 16'h0002};
        tbl[2]  = '{0, 1, 1, 16'h0002, 16'h3456, 16'h0003};
        tbl[3]  = '{0, 1, 1, 16'h0003, 16'h4567, 16'h0004};
        // decode stalled: buffer fills, PC freezes at 2, head held
        tbl[4]  = '{1, 0, 1, 16'h0000, 16'h1234, 16'h0001};
        tbl[5]  = '{0, 0, 1, 16'h0000, 16'h1234, 16'h0002};
        tbl[6]  = '{0, 0, 1, 16'h0000, 16'h1234, 16'h0002};
        tbl[7]  = '{0, 0, 1, 16'h0000, 16'h1234, 16'h0002};
        tbl[8]  = '{0, 0, 1, 16'h0000, 16'h1234, 16'h0002};
        tbl[9]  = '{0, 1, 1, 16'h0001, 16'h2345, 16'h0003};
        tbl[10] = '{0, 1, 1, 16'h0002, 16'h3456, 16'h0004};
        tbl[11] = '{0, 1, 1, 16'h0003, 16'h4567, 16'h0005};

        apply_reset();
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].do_rst) apply_reset();
            step(tbl[i].ready, 1'b0, 16'h0);
            chk("tbl_valid", {15'b0, fetch_valid}, {15'b0, tbl[i].exp_valid});
            chk("tbl_pc", fetch_pc, tbl[i].exp_pc);
            chk("tbl_instr", fetch_instr, tbl[i].exp_instr);
            chk("tbl_addr", pc_address, tbl[i].exp_addr);
        end

        // redirect while full and decode ready: head discarded, target next
        apply_reset();
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h0040);
        chk("redir_valid", {15'b0, fetch_valid}, 16'h0);
        chk("redir_addr", pc_address, 16'h0040);
        step(1'b1, 1'b0, 16'h0);
        chk("redir_target", fetch_pc, 16'h0040);

        // PC wraps past 16'hFFFF
        step(1'b1, 1'b1, 16'hFFFE);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] e;
            step(1'b1, 1'b0, 16'h0);
            e = 16'hFFFE + 16'(i);
            chk("wrap_pc", fetch_pc, e);
        end

        // HALT word at address 5
        mem[5] = 16'hF000;
        apply_reset();
        repeat (6) step(1'b1, 1'b0, 16'h0);
        chk("halt_entry_pc", fetch_pc, 16'h0005);
        chk("halt_entry_instr", fetch_instr, 16'hF000);
        repeat (2) step(1'b1, 1'b0, 16'h0);
`ifdef FETCH_HALT_DETECT_EN
        chk("halt_flag", {15'b0, halted}, 16'h1);
        chk("halt_addr", pc_address, 16'h0006);
        chk("halt_empty", {15'b0, fetch_valid}, 16'h0);
`else
        chk("halt_flag", {15'b0, halted}, 16'h0);
        chk("halt_addr", pc_address, 16'h0008);
        chk("halt_cont", fetch_pc, 16'h0007);
`endif
        step(1'b1, 1'b1, 16'h0000);
        chk("halt_clear", {15'b0, halted}, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        chk("halt_resume", fetch_pc, 16'h0000);
        mem[5] = (16'd5 ^ 16'h0123) & 16'h7FFF;

        // asynchronous reset with two entries buffered
        apply_reset();
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 16'h0);
        chk("midrst_refetch_pc", fetch_pc, 16'h0000);
        chk("midrst_refetch_instr", fetch_instr, 16'h1234);

        // random traffic, including a HALT word reachable at address 20
        mem[20] = 16'hF0AA;
        for (int i = 0; i < 400; i++) begin
            bit          r, rv;
            logic [15:0] rp;
            r  = ($urandom_range(0, 9) < 7);
            rv = ($urandom_range(0, 19) == 0);
            rp = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 30));
            step(r, rv, rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
